// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage, D slot feeding a registered E slot.
// Define SCOREBOARD_EN to build the RAW busy-bit scoreboard and hazard stall.
module decode_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_ID,
  input  logic            inst_valid_ID,
  output logic            inst_ready_ID,
  output logic [4:0]      RAddr1_RF,
  output logic [4:0]      RAddr2_RF,
  input  logic [XLEN-1:0] RD1_RF,
  input  logic [XLEN-1:0] RD2_RF,
  input  logic            WrEn_RF,
  input  logic [4:0]      WAddr_RF,
  output logic            valid_EX,
  input  logic            ready_EX,
  output logic [XLEN-1:0] rs1_val_EX,
  output logic [XLEN-1:0] rs2_val_EX,
  output logic [XLEN-1:0] imm_EX,
  output logic [4:0]      rd_EX,
  output logic [6:0]      opcode_EX,
  output logic [2:0]      funct3_EX,
  output logic [6:0]      funct7_EX,
  output logic            illegal_EX
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic        r_d_valid;
  logic [31:0] r_d_inst;

  logic [6:0]  w_opc;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_use_rd;
  logic        w_illegal;
  logic        w_hazard;
  logic        w_advance;
  logic        w_load;

  assign w_opc = r_d_inst[6:0];
  assign w_rs1 = r_d_inst[19:15];
  assign w_rs2 = r_d_inst[24:20];
  assign w_rd  = w_use_rd ? r_d_inst[11:7] : 5'd0;

  assign w_imm_i = {{20{r_d_inst[31]}}, r_d_inst[31:20]};
  assign w_imm_s = {{20{r_d_inst[31]}}, r_d_inst[31:25], r_d_inst[11:7]};
  assign w_imm_b = {{19{r_d_inst[31]}}, r_d_inst[31], r_d_inst[7],
                    r_d_inst[30:25], r_d_inst[11:8], 1'b0};
  assign w_imm_u = {r_d_inst[31:12], 12'b0};
  assign w_imm_j = {{11{r_d_inst[31]}}, r_d_inst[31], r_d_inst[19:12],
                    r_d_inst[20], r_d_inst[30:21], 1'b0};

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_illegal = 1'b0;
    w_imm     = '0;
    unique case (w_opc)
      OP_LUI, OP_AUIPC: begin
        w_use_rd = 1'b1;
        w_imm    = w_imm_u;
      end
      OP_JAL: begin
        w_use_rd = 1'b1;
        w_imm    = w_imm_j;
      end
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_imm     = w_imm_i;
      end
      OP_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm     = w_imm_b;
      end
      OP_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm     = w_imm_s;
      end
      OP_OP: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_set;
  logic [31:0] w_clr;

  assign w_hazard = r_d_valid &
                    ((w_use_rs1 & r_busy[w_rs1]) |
                     (w_use_rs2 & r_busy[w_rs2]));
  assign w_set = w_advance ? (32'd1 << w_rd) : '0;
  assign w_clr = WrEn_RF ? (32'd1 << WAddr_RF) : '0;

  // set is applied after clear so a same-cycle set wins; bit 0 never sticks
  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
  end
`else
  logic w_unused;
  assign w_hazard = 1'b0;
  assign w_unused = ^{WrEn_RF, WAddr_RF, w_use_rs1, w_use_rs2};
`endif

  assign w_advance     = r_d_valid & ~w_hazard & (~valid_EX | ready_EX);
  assign inst_ready_ID = rst_n & (~r_d_valid | w_advance);
  assign w_load        = inst_valid_ID & inst_ready_ID;

  // D instruction only reloads on a handshake, so read addresses hold when empty
  assign RAddr1_RF = w_rs1;
  assign RAddr2_RF = w_rs2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d_valid  <= 1'b0;
      r_d_inst   <= '0;
      valid_EX   <= 1'b0;
      rs1_val_EX <= '0;
      rs2_val_EX <= '0;
      imm_EX     <= '0;
      rd_EX      <= '0;
      opcode_EX  <= '0;
      funct3_EX  <= '0;
      funct7_EX  <= '0;
      illegal_EX <= 1'b0;
    end else begin
      if (w_load) begin
        r_d_valid <= 1'b1;
        r_d_inst  <= inst_ID;
      end else if (w_advance) begin
        r_d_valid <= 1'b0;
      end
      if (w_advance) begin
        valid_EX   <= 1'b1;
        rs1_val_EX <= RD1_RF;
        rs2_val_EX <= RD2_RF;
        imm_EX     <= w_imm;
        rd_EX      <= w_rd;
        opcode_EX  <= w_opc;
        funct3_EX  <= r_d_inst[14:12];
        funct7_EX  <= r_d_inst[31:25];
        illegal_EX <= w_illegal;
      end else if (ready_EX) begin
        valid_EX <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed and randomized checks of decode_issue.
// Expectations adapt to whether SCOREBOARD_EN is defined.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_ID = '0;
  logic        inst_valid_ID = 1'b0;
  logic        inst_ready_ID;
  logic [4:0]  RAddr1_RF, RAddr2_RF;
  logic [31:0] RD1_RF, RD2_RF;
  logic        WrEn_RF = 1'b0;
  logic [4:0]  WAddr_RF = '0;
  logic        valid_EX;
  logic        ready_EX = 1'b0;
  logic [31:0] rs1_val_EX, rs2_val_EX, imm_EX;
  logic [4:0]  rd_EX;
  logic [6:0]  opcode_EX;
  logic [2:0]  funct3_EX;
  logic [6:0]  funct7_EX;
  logic        illegal_EX;

  logic [31:0]  rf [32];
  logic [118:0] ex_bus;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign RD1_RF = rf[RAddr1_RF];
  assign RD2_RF = rf[RAddr2_RF];
  assign ex_bus = {rs1_val_EX, rs2_val_EX, imm_EX, rd_EX, opcode_EX,
                   funct3_EX, funct7_EX, illegal_EX};

  decode_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_ID(inst_ID), .inst_valid_ID(inst_valid_ID),
    .inst_ready_ID(inst_ready_ID),
    .RAddr1_RF(RAddr1_RF), .RAddr2_RF(RAddr2_RF),
    .RD1_RF(RD1_RF), .RD2_RF(RD2_RF),
    .WrEn_RF(WrEn_RF), .WAddr_RF(WAddr_RF),
    .valid_EX(valid_EX), .ready_EX(ready_EX),
    .rs1_val_EX(rs1_val_EX), .rs2_val_EX(rs2_val_EX),
    .imm_EX(imm_EX), .rd_EX(rd_EX), .opcode_EX(opcode_EX),
    .funct3_EX(funct3_EX), .funct7_EX(funct7_EX),
    .illegal_EX(illegal_EX)
  );

  function automatic logic [31:0] enc_i(input logic [6:0] op,
    input logic [4:0] rd, input logic [2:0] f3,
    input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op,
    input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  // Reference decode straight from the opcode table and immediate formulas.
  function automatic void ref_dec(input logic [31:0] in,
    output logic [31:0] imm, output logic [4:0] rd, output logic ill);
    int vi, vs, vb, vj;
    logic [31:0] vu;
    vi = int'($signed(in[31:20]));
    vs = int'($signed({in[31:25], in[11:7]}));
    vb = int'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
    vj = int'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
    vu = {in[31:12], 12'h000};
    ill = 1'b0;
    rd  = in[11:7];
    imm = 32'd0;
    case (in[6:0])
      7'b0110111, 7'b0010111: imm = vu;
      7'b1101111: imm = vj;
      7'b1100111, 7'b0000011, 7'b0010011: imm = vi;
      7'b1100011: begin imm = vb; rd = 5'd0; end
      7'b0100011: begin imm = vs; rd = 5'd0; end
      7'b0110011: imm = 32'd0;
      default: begin ill = 1'b1; rd = 5'd0; end
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(9))
      0: r[6:0] = 7'h37;
      1: r[6:0] = 7'h17;
      2: r[6:0] = 7'h6F;
      3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h03;
      6: r[6:0] = 7'h23;
      7: r[6:0] = 7'h13;
      8: r[6:0] = 7'h33;
      default: ;
    endcase
    return r;
  endfunction

  task automatic rf_init();
    rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) rf[i] = 32'h00F0_0000 + 32'h0101_0101 * i;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inst_valid_ID = 1'b0;
    ready_EX = 1'b0;
    WrEn_RF = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inst_valid_ID = 1'b1;
    inst_ID = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd5);
    ready_EX = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (valid_EX !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_EX); end
    checks++; if (ex_bus !== '0) begin failures++; $display("FAIL reset_ex_outputs got=%h exp=0", ex_bus); end
    checks++; if ({RAddr1_RF, RAddr2_RF} !== 10'd0) begin failures++; $display("FAIL reset_raddr got=%h exp=0", {RAddr1_RF, RAddr2_RF}); end
    checks++; if (inst_ready_ID !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", inst_ready_ID); end
    rst_n = 1'b1;
    inst_valid_ID = 1'b0;
    #1;
    checks++; if (inst_ready_ID !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", inst_ready_ID); end
    inst_valid_ID = 1'b1;
    @(negedge clk);
    inst_ID = enc_r(7'd0, 5'd4, 5'd3, 3'd0, 5'd2, 7'h33);
    @(negedge clk);
    inst_valid_ID = 1'b0;
    ready_EX = 1'b0;
    #1;
    checks++; if (valid_EX !== 1'b1) begin failures++; $display("FAIL midreset_pre got=%b exp=1", valid_EX); end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (valid_EX !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", valid_EX); end
    rst_n = 1'b1;
    ready_EX = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++; if (valid_EX !== 1'b0) begin failures++; $display("FAIL midreset_noissue cyc=%0d got=%b exp=0", k, valid_EX); end
    end
  endtask

  task automatic test_back_to_back();
    rf_init();
    do_reset();
    ready_EX = 1'b1;
    inst_valid_ID = 1'b1;
    inst_ID = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd5);
    @(negedge clk);
    inst_ID = enc_r(7'd0, 5'd4, 5'd3, 3'd0, 5'd2, 7'h33);
    #1;
    checks++; if (valid_EX !== 1'b0) begin failures++; $display("FAIL b2b_latency got=%b exp=0", valid_EX); end
    checks++; if (inst_ready_ID !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", inst_ready_ID); end
    @(negedge clk);
    inst_valid_ID = 1'b0;
    #1;
    checks++; if ({valid_EX, rd_EX, imm_EX, opcode_EX, rs1_val_EX} !== {1'b1, 5'd1, 32'd5, 7'h13, 32'd0})
      begin failures++; $display("FAIL b2b_first got=%b/%0d/%h/%h/%h exp=1/1/5/13/0", valid_EX, rd_EX, imm_EX, opcode_EX, rs1_val_EX); end
    checks++; if ({RAddr1_RF, RAddr2_RF} !== {5'd3, 5'd4}) begin failures++; $display("FAIL b2b_raddr got=%0d/%0d exp=3/4", RAddr1_RF, RAddr2_RF); end
    @(negedge clk);
    #1;
    checks++; if ({valid_EX, rd_EX, imm_EX, rs1_val_EX, rs2_val_EX} !== {1'b1, 5'd2, 32'd0, rf[3], rf[4]})
      begin failures++; $display("FAIL b2b_second got=%b/%0d/%h/%h/%h exp=1/2/0/%h/%h", valid_EX, rd_EX, imm_EX, rs1_val_EX, rs2_val_EX, rf[3], rf[4]); end
    @(negedge clk);
    #1;
    checks++; if (valid_EX !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", valid_EX); end
    checks++; if ({RAddr1_RF, RAddr2_RF} !== {5'd3, 5'd4}) begin failures++; $display("FAIL b2b_raddr_hold got=%0d/%0d exp=3/4", RAddr1_RF, RAddr2_RF); end
  endtask

  task automatic test_raw();
    rf_init();
    rf[5] = 32'hDEAD_BEEF;
    do_reset();
    ready_EX = 1'b1;
    inst_valid_ID = 1'b1;
    inst_ID = enc_i(7'h13, 5'd5, 3'd0, 5'd0, 12'd7);
    @(negedge clk);
    inst_ID = enc_r(7'd0, 5'd5, 5'd5, 3'd0, 5'd6, 7'h33);
    @(negedge clk);
    inst_valid_ID = 1'b0;
    #1;
    checks++; if ({valid_EX, rd_EX, imm_EX} !== {1'b1, 5'd5, 32'd7}) begin failures++; $display("FAIL raw_producer got=%b/%0d/%h exp=1/5/7", valid_EX, rd_EX, imm_EX); end
`ifdef SCOREBOARD_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++; if ({valid_EX, inst_ready_ID} !== 2'b00) begin failures++; $display("FAIL raw_stall cyc=%0d got=%b%b exp=00", k, valid_EX, inst_ready_ID); end
    end
    @(negedge clk);
    rf[5] = 32'd7;
    WrEn_RF = 1'b1;
    WAddr_RF = 5'd5;
    #1;
    checks++; if (valid_EX !== 1'b0) begin failures++; $display("FAIL raw_wb_cycle got=%b exp=0", valid_EX); end
    @(negedge clk);
    WrEn_RF = 1'b0;
    #1;
    checks++; if ({valid_EX, inst_ready_ID} !== 2'b01) begin failures++; $display("FAIL raw_release got=%b%b exp=01", valid_EX, inst_ready_ID); end
    @(negedge clk);
    #1;
    checks++; if ({valid_EX, rd_EX, rs1_val_EX, rs2_val_EX} !== {1'b1, 5'd6, 32'd7, 32'd7})
      begin failures++; $display("FAIL raw_issue got=%b/%0d/%h/%h exp=1/6/7/7", valid_EX, rd_EX, rs1_val_EX, rs2_val_EX); end
`else
    @(negedge clk);
    #1;
    checks++; if ({valid_EX, rd_EX, rs1_val_EX, rs2_val_EX} !== {1'b1, 5'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF})
      begin failures++; $display("FAIL raw_nostall got=%b/%0d/%h/%h exp=1/6/deadbeef/deadbeef", valid_EX, rd_EX, rs1_val_EX, rs2_val_EX); end
`endif
  endtask

  task automatic test_immediates();
    logic [31:0] ins [3];
    logic [31:0] eimm [3];
    logic [4:0]  erd [3];
    ins[0] = enc_b(5'd0, 5'd0, 3'd0, 13'h1FFC);     eimm[0] = 32'hFFFF_FFFC; erd[0] = 5'd0;
    ins[1] = enc_u(7'h37, 5'd1, 20'h12345);         eimm[1] = 32'h1234_5000; erd[1] = 5'd1;
    ins[2] = enc_s(5'd4, 5'd3, 3'd2, 12'h7FF);      eimm[2] = 32'h0000_07FF; erd[2] = 5'd0;
    rf_init();
    do_reset();
    ready_EX = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inst_valid_ID = (i < 3);
      if (i < 3) inst_ID = ins[i];
      #1;
      if (i >= 2) begin
        checks++;
        if ({valid_EX, imm_EX, rd_EX, illegal_EX} !== {1'b1, eimm[i-2], erd[i-2], 1'b0})
          begin failures++; $display("FAIL imm_%0d got=%b/%h/%0d/%b exp=1/%h/%0d/0", i-2, valid_EX, imm_EX, rd_EX, illegal_EX, eimm[i-2], erd[i-2]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_x0_illegal();
    logic [31:0] ins [4];
    logic [31:0] eimm [4];
    logic [4:0]  erd [4];
    logic        eill [4];
    ins[0] = enc_i(7'h13, 5'd0, 3'd0, 5'd0, 12'd1);           eimm[0] = 32'd1; erd[0] = 5'd0;  eill[0] = 1'b0;
    ins[1] = enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd10, 7'h33);     eimm[1] = 32'd0; erd[1] = 5'd10; eill[1] = 1'b0;
    ins[2] = enc_i(7'h13, 5'd5, 3'd0, 5'd0, 12'd1);           eimm[2] = 32'd1; erd[2] = 5'd5;  eill[2] = 1'b0;
    ins[3] = {7'h55, 5'd5, 5'd5, 3'd7, 5'd5, 7'h7F};          eimm[3] = 32'd0; erd[3] = 5'd0;  eill[3] = 1'b1;
    rf_init();
    do_reset();
    ready_EX = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inst_valid_ID = (i < 4);
      if (i < 4) inst_ID = ins[i];
      #1;
      if (i >= 2) begin
        checks++;
        if ({valid_EX, imm_EX, rd_EX, illegal_EX} !== {1'b1, eimm[i-2], erd[i-2], eill[i-2]})
          begin failures++; $display("FAIL x0ill_%0d got=%b/%h/%0d/%b exp=1/%h/%0d/%b", i-2, valid_EX, imm_EX, rd_EX, illegal_EX, eimm[i-2], erd[i-2], eill[i-2]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_pressure();
    logic [118:0] saved;
    rf_init();
    do_reset();
    ready_EX = 1'b0;
    inst_valid_ID = 1'b1;
    inst_ID = enc_i(7'h13, 5'd7, 3'd0, 5'd0, 12'd3);
    @(negedge clk);
    inst_ID = enc_r(7'd0, 5'd4, 5'd3, 3'd0, 5'd8, 7'h33);
    #1;
    checks++; if (inst_ready_ID !== 1'b1) begin failures++; $display("FAIL bp_ready_e_empty got=%b exp=1", inst_ready_ID); end
    @(negedge clk);
    inst_ID = enc_i(7'h13, 5'd9, 3'd0, 5'd0, 12'd9);
    #1;
    checks++; if ({valid_EX, rd_EX, inst_ready_ID} !== {1'b1, 5'd7, 1'b0}) begin failures++; $display("FAIL bp_full got=%b/%0d/%b exp=1/7/0", valid_EX, rd_EX, inst_ready_ID); end
    saved = ex_bus;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({valid_EX, inst_ready_ID, RAddr1_RF, ex_bus} !== {1'b1, 1'b0, 5'd3, saved})
        begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%0d/%h exp=1/0/3/%h", k, valid_EX, inst_ready_ID, RAddr1_RF, ex_bus, saved); end
    end
    @(negedge clk);
    ready_EX = 1'b1;
    #1;
    checks++; if (inst_ready_ID !== 1'b1) begin failures++; $display("FAIL bp_resume_ready got=%b exp=1", inst_ready_ID); end
    @(negedge clk);
    inst_valid_ID = 1'b0;
    #1;
    checks++; if ({valid_EX, rd_EX} !== {1'b1, 5'd8}) begin failures++; $display("FAIL bp_second got=%b/%0d exp=1/8", valid_EX, rd_EX); end
    @(negedge clk);
    #1;
    checks++; if ({valid_EX, rd_EX} !== {1'b1, 5'd9}) begin failures++; $display("FAIL bp_third got=%b/%0d exp=1/9", valid_EX, rd_EX); end
    @(negedge clk);
    #1;
    checks++; if (valid_EX !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", valid_EX); end
  endtask

  task automatic test_random();
    logic [31:0]  q [$];
    logic [4:0]   wbq [$];
    logic [31:0]  e, eimm;
    logic [4:0]   erd;
    logic         eill, drain, stall_prev;
    logic [118:0] saved, exp_bus;
    int issued;
    issued = 0;
    stall_prev = 1'b0;
    saved = '0;
    rf_init();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drain = (c >= 500);
      inst_valid_ID = !drain && ($urandom_range(3) != 0);
      inst_ID = rand_inst();
      ready_EX = drain || ($urandom_range(3) != 0);
      WrEn_RF = 1'b0;
`ifdef SCOREBOARD_EN
      if (wbq.size() > 0 && $urandom_range(1) == 1) begin
        WrEn_RF = 1'b1;
        WAddr_RF = wbq.pop_front();
      end
`else
      WrEn_RF = ($urandom_range(7) == 0);
      WAddr_RF = 5'($urandom_range(31));
`endif
      #1;
      if (stall_prev) begin
        checks++;
        if ({valid_EX, ex_bus} !== {1'b1, saved})
          begin failures++; $display("FAIL rand_stable cyc=%0d got=%b/%h exp=1/%h", c, valid_EX, ex_bus, saved); end
      end
      if (valid_EX && ready_EX) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rand_spurious cyc=%0d got=issue exp=none", c);
        end else begin
          e = q.pop_front();
          ref_dec(e, eimm, erd, eill);
          exp_bus = {rf[e[19:15]], rf[e[24:20]], eimm, erd, e[6:0], e[14:12], e[31:25], eill};
          if (ex_bus !== exp_bus)
            begin failures++; $display("FAIL rand_issue cyc=%0d inst=%h got=%h exp=%h", c, e, ex_bus, exp_bus); end
`ifdef SCOREBOARD_EN
          if (erd != 5'd0) wbq.push_back(erd);
`endif
          issued++;
        end
      end
      if (inst_valid_ID && inst_ready_ID) q.push_back(inst_ID);
      stall_prev = valid_EX && !ready_EX;
      saved = ex_bus;
      @(negedge clk);
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d exp=0 pending", q.size()); end
    checks++; if (issued < 100) begin failures++; $display("FAIL rand_throughput got=%0d exp>=100", issued); end
  endtask

  initial begin
    rf_init();
    test_reset();
    test_back_to_back();
    test_raw();
    test_immediates();
    test_x0_illegal();
    test_back_pressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
